// File: rtl/subbytes_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : subbytes_lanes                                               |
// | Description : Time-multiplexed AES SubBytes engine. LANES registered S-box |
// |               lookups per cycle, 16/LANES issue beats per 128-bit block,   |
// |               valid/ready handshakes on both sides.                        |
// |               Optional INV_SUBBYTES_EN adds the inv port and an inverse   |
// |               S-box ROM per lane.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module subbytes_lanes #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
`ifdef INV_SUBBYTES_EN
    ,
    input  logic         inv
`endif
);

    localparam int         BEATS       = 16 / LANES;
    localparam int         c_LW        = LANES * 8;
    localparam logic [4:0] c_BEATS_CNT = 5'(BEATS);
    localparam logic [4:0] c_LAST_BEAT = 5'(BEATS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Forward S-box, entry x at index x (index 0 is the leftmost byte).
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef INV_SUBBYTES_EN
    // Inverse S-box, same indexing as the forward table.
    localparam logic [0:255][7:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
`endif

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("subbytes_lanes: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [127:0]    src_q;
    logic [127:0]    dst_q;
    logic [127:0]    dst_d;
    logic [4:0]      issue_cnt_q;
    logic [4:0]      wr_cnt_q;
    logic            lat_vld_q;
    logic [c_LW-1:0] w_rom_word;
    logic            w_issue_en;
    logic            w_accept;
    logic            w_wr_last;
`ifdef INV_SUBBYTES_EN
    logic            inv_q;
`endif

    assign w_accept   = (state_q == c_IDLE) && in_valid;
    assign w_issue_en = (state_q == c_RUN) && (issue_cnt_q < c_BEATS_CNT);
    assign w_wr_last  = lat_vld_q && (wr_cnt_q == c_LAST_BEAT);

    // The source register is shifted down one beat per issue, so every lane
    // always reads a fixed byte position; results enter dst from the top and
    // land at their original byte positions after the final beat.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] fwd_q;
`ifdef INV_SUBBYTES_EN
        logic [7:0] inv_rom_q;

        // Registered forward and inverse ROM reads of this lane's byte.
        always_ff @(posedge clk) begin
            if (w_issue_en) begin
                fwd_q     <= c_SBOX[src_q[l*8 +: 8]];
                inv_rom_q <= c_INV_SBOX[src_q[l*8 +: 8]];
            end
        end

        assign w_rom_word[l*8 +: 8] = inv_q ? inv_rom_q : fwd_q;
`else
        // Registered forward ROM read of this lane's byte.
        always_ff @(posedge clk) begin
            if (w_issue_en) begin
                fwd_q <= c_SBOX[src_q[l*8 +: 8]];
            end
        end

        assign w_rom_word[l*8 +: 8] = fwd_q;
`endif
    end

    if (LANES == 16) begin : g_dst_full
        assign dst_d = w_rom_word;
    end else begin : g_dst_shift
        assign dst_d = {w_rom_word, dst_q[127:c_LW]};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (in_valid)  state_d = c_RUN;
            c_RUN:   if (w_wr_last) state_d = c_DONE;
            c_DONE:  if (out_ready) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            c_IDLE:  in_ready  = 1'b1;
            c_RUN:   busy      = 1'b1;
            c_DONE:  begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: capture on accept, issue/write counters that saturate at the
    // end of the block, and the write pipeline lagging issue by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q       <= '0;
            dst_q       <= '0;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            lat_vld_q   <= 1'b0;
`ifdef INV_SUBBYTES_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            lat_vld_q <= w_issue_en;
            if (w_accept) begin
                src_q       <= in_state;
                issue_cnt_q <= '0;
                wr_cnt_q    <= '0;
`ifdef INV_SUBBYTES_EN
                inv_q       <= inv;
`endif
            end else begin
                if (w_issue_en) begin
                    src_q       <= src_q >> c_LW;
                    issue_cnt_q <= issue_cnt_q + 5'd1;
                end
                if (lat_vld_q) begin
                    dst_q <= dst_d;
                    if (wr_cnt_q < c_LAST_BEAT) begin
                        wr_cnt_q <= wr_cnt_q + 5'd1;
                    end
                end
            end
        end
    end

    assign out_state = dst_q;

endmodule
`default_nettype wire

// File: tb/tb_subbytes_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_subbytes_lanes                                            |
// | Description : Directed self-checking bench for subbytes_lanes with three   |
// |               instances (LANES = 4, 16, 1). Inverse vectors run only when  |
// |               INV_SUBBYTES_EN is defined.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_subbytes_lanes;

    localparam logic [127:0] c_FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] c_FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] c_ALL_00   = 128'h0;
    localparam logic [127:0] c_ALL_63   = {16{8'h63}};
    localparam logic [127:0] c_ALL_FF   = {16{8'hff}};
    localparam logic [127:0] c_ALL_16   = {16{8'h16}};
    localparam logic [127:0] c_ALL_53   = {16{8'h53}};
    localparam logic [127:0] c_ALL_ED   = {16{8'hed}};

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy, inv;
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    subbytes_lanes #(.LANES(4)) u_l4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_state  (in_state[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_state (out_state[0]),
        .busy      (busy[0])
`ifdef INV_SUBBYTES_EN
        ,.inv      (inv[0])
`endif
    );

    subbytes_lanes #(.LANES(16)) u_l16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_state  (in_state[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_state (out_state[1]),
        .busy      (busy[1])
`ifdef INV_SUBBYTES_EN
        ,.inv      (inv[1])
`endif
    );

    subbytes_lanes #(.LANES(1)) u_l1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[2]),
        .in_ready  (in_ready[2]),
        .in_state  (in_state[2]),
        .out_valid (out_valid[2]),
        .out_ready (out_ready[2]),
        .out_state (out_state[2]),
        .busy      (busy[2])
`ifdef INV_SUBBYTES_EN
        ,.inv      (inv[2])
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; counts rising edges until out_valid is seen.
    task automatic wait_done(input int d, output int n);
        n = 0;
        while (out_valid[d] !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    // One full block with out_ready held high: latency, result, handshake.
    task automatic run_block(input int d, input logic [127:0] data, input logic inv_v,
                             input logic [127:0] exp, input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        chk({tag, " in_ready idle"}, 128'(in_ready[d]), 128'd1);
        in_valid[d]  = 1'b1;
        in_state[d]  = data;
        inv[d]       = inv_v;
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        chk({tag, " busy after accept"}, 128'(busy[d]), 128'd1);
        wait_done(d, n);
        chk({tag, " latency"}, 128'(n), 128'(exp_lat));
        chk({tag, " out_state"}, out_state[d], exp);
        @(negedge clk);
        chk({tag, " out_valid after hs"}, 128'(out_valid[d]), 128'd0);
        chk({tag, " in_ready after hs"}, 128'(in_ready[d]), 128'd1);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        inv       = '0;
        for (int i = 0; i < 3; i++) in_state[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset in_ready d%0d", i), 128'(in_ready[i]), 128'd1);
            chk($sformatf("reset out_valid d%0d", i), 128'(out_valid[i]), 128'd0);
            chk($sformatf("reset busy d%0d", i), 128'(busy[i]), 128'd0);
            chk($sformatf("reset out_state d%0d", i), out_state[i], 128'd0);
        end
        reset = 1'b0;

        // FIPS-197 round-1 vector on the 4-lane engine.
        run_block(0, c_FIPS_IN, 1'b0, c_FIPS_OUT, 5, "t1 l4 fips");

        // Zero and all-FF inputs at 16 lanes and 1 lane.
        run_block(1, c_ALL_00, 1'b0, c_ALL_63, 2, "t2 l16 zero");
        run_block(2, c_ALL_00, 1'b0, c_ALL_63, 17, "t2 l1 zero");
        run_block(1, c_ALL_FF, 1'b0, c_ALL_16, 2, "t2 l16 ff");
        run_block(2, c_ALL_FF, 1'b0, c_ALL_16, 17, "t2 l1 ff");
        run_block(0, c_ALL_FF, 1'b0, c_ALL_16, 5, "t2 l4 ff");

        // Back-pressure: DONE held while out_ready stays low.
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_state[0]  = c_FIPS_IN;
        out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_done(0, n);
        chk("t3 latency", 128'(n), 128'd5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3 hold out_valid", 128'(out_valid[0]), 128'd1);
            chk("t3 hold in_ready", 128'(in_ready[0]), 128'd0);
            chk("t3 hold out_state", out_state[0], c_FIPS_OUT);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("t3 release out_valid", 128'(out_valid[0]), 128'd0);
        chk("t3 release in_ready", 128'(in_ready[0]), 128'd1);

        // Reset in the middle of RUN discards the block.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_state[0] = c_ALL_00;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t4 busy before reset", 128'(busy[0]), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t4 out_valid after reset", 128'(out_valid[0]), 128'd0);
        chk("t4 busy after reset", 128'(busy[0]), 128'd0);
        chk("t4 in_ready after reset", 128'(in_ready[0]), 128'd1);
        reset = 1'b0;
        run_block(0, c_ALL_53, 1'b0, c_ALL_ED, 5, "t4 l4 53");

        // Input changes during RUN are ignored; second block waits for IDLE.
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_state[0]  = c_FIPS_IN;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_state[0] = c_ALL_00;
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 40) begin
            chk("t5 in_ready during run", 128'(in_ready[0]), 128'd0);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("t5 first latency", 128'(n), 128'd5);
        chk("t5 first out_state", out_state[0], c_FIPS_OUT);
        @(negedge clk);
        chk("t5 idle in_ready", 128'(in_ready[0]), 128'd1);
        chk("t5 idle busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        chk("t5 second accepted", 128'(busy[0]), 128'd1);
        in_valid[0] = 1'b0;
        wait_done(0, n);
        chk("t5 second latency", 128'(n), 128'd5);
        chk("t5 second out_state", out_state[0], c_ALL_63);
        @(negedge clk);
        chk("t5 second handshake", 128'(out_valid[0]), 128'd0);

`ifdef INV_SUBBYTES_EN
        // Inverse substitution selected at acceptance.
        run_block(0, c_FIPS_OUT, 1'b1, c_FIPS_IN, 5, "t6 l4 inv fips");
        run_block(1, c_ALL_63, 1'b1, c_ALL_00, 2, "t6 l16 inv 63");
        run_block(2, c_ALL_63, 1'b1, c_ALL_00, 17, "t6 l1 inv 63");
        run_block(0, c_FIPS_IN, 1'b0, c_FIPS_OUT, 5, "t6 l4 fwd again");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
